fpu_result_queue: RTL
=====================

// Module: fpu_result_queue
// PURPOSE
//  Receiving end of the FPU's fixed-latency, non-stallable execution pipe. Captures one result per
//  cycle and hands results downstream over a valid/ready interface.
//  The pipe has no clock enable, so the block also issues credits to the FPU issue logic. An
//  operation may enter only when its result is guaranteed a queue slot.
// PARAMETERS
//  DATA_WIDTH  32  result word width (bits)
//  DEPTH       8   queue entries; power of 2, >=2
// PORTS
//  I_Clk        in   1           clock, all state on rising edge
//  I_nReset     in   1           asynchronous, active-low reset
//  I_Issue      in   1           issue logic launched one op into the pipe this cycle
//  O_Issue_Ok   out  1           a credit is available; I_Issue is legal this cycle
//  I_Res_Valid  in   1           pipe output valid (one result per cycle max)
//  I_Res_Data   in   DATA_WIDTH  pipe output result
//  O_Valid      out  1           head entry valid
//  O_Data       out  DATA_WIDTH  head entry data
//  I_Ready      in   1           downstream accepts; transfer when O_Valid & I_Ready
//  O_Count      out  CW          stored entries, CW=$clog2(DEPTH+1)
//  O_Err        out  1           sticky protocol error
// BEHAVIOUR
//  - Reset (async assert, sync release):
//      O_Issue_Ok=1, O_Valid=0, O_Data=0, O_Count=0, O_Err=0.
//      Pointers, in-flight count and storage are cleared.
//      Any in-flight ops are forgotten; results arriving after reset release set O_Err.
//  - Counters, all registered:
//      Count = stored entries.
//      Inflight = issued ops whose results have not yet arrived.
//      Inflight next = Inflight + I_Issue - I_Res_Valid; issue and arrival in one cycle leave it unchanged.
//  - O_Issue_Ok = (Count + Inflight) < DEPTH. Decoded from registers only; no combinational path from inputs.
//  - Reserved slots: an issue with O_Issue_Ok=1 holds a slot until its result is stored and popped.
//  - Push: I_Res_Valid writes I_Res_Data at wr_ptr; wr_ptr and Count increment.
//  - Pop: O_Valid & I_Ready advances rd_ptr and decrements Count.
//  - Push and pop in the same cycle: Count unchanged. Legal when full and when empty (no bypass).
//  - First-word-fall-through: O_Valid = (Count!=0); O_Data = mem[rd_ptr].
//      Result arriving at edge N is visible at O_Valid after edge N.
//  - I_Ready while O_Valid=0: ignored.
//  - Pointers: log2(DEPTH) bits, natural wrap from DEPTH-1 to 0.
//  - O_Err sticky until reset. Set by any of:
//      (a) I_Issue while O_Issue_Ok=0; the op is still counted, saturating at DEPTH;
//      (b) I_Res_Valid while Inflight=0; the result is dropped;
//      (c) push while full with no pop; the result is dropped and pointers are unchanged.
// CONFIGURATION
//  Macro FPU_RESQ_BYPASS_EN.
//  - Defined: when Count==0 and I_Res_Valid, O_Valid=1 and O_Data=I_Res_Data in the same cycle
//    (zero latency).
//      If I_Ready is also 1, the result is consumed and not stored.
//      If I_Ready is 0, the result is stored as a normal push.
//  - Undefined: no bypass; minimum input-to-output latency is 1 cycle; O_Valid/O_Data come from
//    storage only.
// STRUCTURE
//  - fpu_pkg holds:
//      fpu_res_t (logic [DATA_WIDTH-1:0])
//      RESQ_DEPTH_DEF=8
//      function resq_cw(depth) returning the count width.
//  - One sub-module, fpu_resq_credit: Inflight counter, O_Issue_Ok decode, and error terms (a)/(b).
//  - Storage and pointers stay in the top level.
// TESTING
//  1 Reset: hold I_nReset=0 mid-stream with Count=5.
//      -> all outputs at reset values immediately; O_Issue_Ok=1 after release.
//  2 Credits: DEPTH=8, I_Ready=0, issue 8 ops back-to-back.
//      -> O_Issue_Ok=0 from the cycle after the 8th issue; 8 results later arrive; Count=8; O_Err=0.
//  3 Full + simultaneous: Count=8, pop and push in the same cycle.
//      -> Count stays 8; data order preserved across the pointer wrap 7->0.
//  4 Ordering: results 0xA0..0xAF streamed while I_Ready toggles 1,0,1,0.
//      -> output sequence is exactly 0xA0..0xAF; no loss or duplication.
//  5 Errors:
//      I_Issue when O_Issue_Ok=0 -> O_Err=1 next cycle, held until reset.
//      Fresh reset, then I_Res_Valid with no issue -> O_Err=1; Count=0.
//  6 Bypass (with FPU_RESQ_BYPASS_EN): Count=0, I_Res_Valid=1, I_Ready=1, data 0x3F800000.
//      -> O_Valid=1 and O_Data=0x3F800000 in the same cycle; Count stays 0.
//      Without the macro: O_Valid rises one cycle later.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and sizing helpers for the FPU result queue.
// The count width must hold DEPTH itself, hence depth+1 states.
package fpu_pkg;

  localparam int FPU_DATA_WIDTH = 32;
  localparam int RESQ_DEPTH_DEF = 8;

  typedef logic [FPU_DATA_WIDTH-1:0] fpu_res_t;

  function automatic int resq_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fpu_resq_credit.sv
// Credit tracker: in-flight op counter, registered issue-ok decode, and issue/orphan-result error terms.
// Zero-cycle error terms; issue_ok depends on registered state only, so issue logic sees no input loop.
module fpu_resq_credit
  import fpu_pkg::*;
#(
  parameter  int DEPTH = RESQ_DEPTH_DEF,
  localparam int CW    = resq_cw(DEPTH)
) (
  input  logic          I_Clk,
  input  logic          I_nReset,
  input  logic          issue,
  input  logic          res_valid,
  input  logic [CW-1:0] count,
  output logic          issue_ok,
  output logic          issue_err,
  output logic          orphan
);

  logic [CW-1:0] inflight_q;
  logic [CW:0]   sum;
  logic [CW:0]   inflight_nxt;

  assign sum       = {1'b0, count} + {1'b0, inflight_q};
  assign issue_ok  = (sum < (CW+1)'(DEPTH));
  assign issue_err = issue & ~issue_ok;
  // A result with nothing outstanding cannot belong to any op, even one issued this cycle.
  assign orphan    = res_valid & (inflight_q == '0);

  always_comb begin
    inflight_nxt = {1'b0, inflight_q} + (CW+1)'(issue);
    if (res_valid && !orphan) begin
      inflight_nxt = inflight_nxt - (CW+1)'(1);
    end
    if (inflight_nxt > (CW+1)'(DEPTH)) begin
      inflight_nxt = (CW+1)'(DEPTH);
    end
  end

  always_ff @(posedge I_Clk or negedge I_nReset) begin
    if (!I_nReset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_nxt[CW-1:0];
    end
  end

endmodule

// File: rtl/fpu_result_queue.sv
// FWFT queue behind the non-stallable FPU pipe; 1-cycle latency (0 with FPU_RESQ_BYPASS_EN), pipe throttled by credits.
// Downstream stalls via I_Ready; the pipe itself is never stalled, O_Issue_Ok gates new issues instead.
module fpu_result_queue
  import fpu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = RESQ_DEPTH_DEF,
  localparam int CW         = resq_cw(DEPTH),
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  I_Clk,
  input  logic                  I_nReset,
  input  logic                  I_Issue,
  output logic                  O_Issue_Ok,
  input  logic                  I_Res_Valid,
  input  logic [DATA_WIDTH-1:0] I_Res_Data,
  output logic                  O_Valid,
  output logic [DATA_WIDTH-1:0] O_Data,
  input  logic                  I_Ready,
  output logic [CW-1:0]         O_Count,
  output logic                  O_Err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  err_q;

  logic issue_err;
  logic orphan;
  logic accept;
  logic stored_vld;
  logic full;
  logic pop;
  logic push;
  logic overflow;
  logic wr_en;
  logic bypass_take;

  fpu_resq_credit #(
    .DEPTH (DEPTH)
  ) u_credit (
    .I_Clk     (I_Clk),
    .I_nReset  (I_nReset),
    .issue     (I_Issue),
    .res_valid (I_Res_Valid),
    .count     (count_q),
    .issue_ok  (O_Issue_Ok),
    .issue_err (issue_err),
    .orphan    (orphan)
  );

  assign accept     = I_Res_Valid & ~orphan;
  assign stored_vld = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = stored_vld & I_Ready;

`ifdef FPU_RESQ_BYPASS_EN
  logic bypass;
  assign bypass      = accept & ~stored_vld;
  assign bypass_take = bypass & I_Ready;
  assign O_Valid     = stored_vld | bypass;
  assign O_Data      = bypass ? I_Res_Data : mem[rd_ptr];
`else
  assign bypass_take = 1'b0;
  assign O_Valid     = stored_vld;
  assign O_Data      = mem[rd_ptr];
`endif

  // When full, a same-cycle pop frees the head slot that wr_ptr already points at.
  assign push     = accept & ~bypass_take;
  assign overflow = push & full & ~pop;
  assign wr_en    = push & ~overflow;

  always_ff @(posedge I_Clk or negedge I_nReset) begin
    if (!I_nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= I_Res_Data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge I_Clk or negedge I_nReset) begin
    if (!I_nReset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | issue_err | orphan | overflow;
    end
  end

  assign O_Count = count_q;
  assign O_Err   = err_q;

endmodule
